// File: rtl/mano_cache_pkg.sv
// mano_cache_pkg
//   Shared definitions for the Mano CPU cache controller: address/data
//   geometry, the logical line layout, FSM state encodings and a
//   saturating counter helper.
//   Optional feature macro: MANO_CACHE_STATS_EN (hit/miss counters).
package mano_cache_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 8;
  localparam int TAG_W   = ADDR_W - INDEX_W;   // 4
  localparam int LINES   = 1 << INDEX_W;       // 256 one-word lines
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Logical view of one line. Data and tag live in mano_cache_store;
  // dirty and valid are flop vectors in the controller.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              dirty;
    logic              valid;
  } line_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mano_cache_store.sv
// mano_cache_store
//   256-entry data/tag array. Combinational read by index, one synchronous
//   write port. No reset: line validity is tracked by the controller.
// Ports:
//   clk                       clock
//   rd_idx -> rd_data/rd_tag  asynchronous read
//   we, wr_idx, wr_data, wr_tag  write on rising edge when we=1
module mano_cache_store
  import mano_cache_pkg::*;
(
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [DATA_W-1:0]  rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  assign rd_data = data_mem[rd_idx];
  assign rd_tag  = tag_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

endmodule

// File: rtl/mano_cache_ctrl.sv
// mano_cache_ctrl
//   Sequencer for a 256-line direct-mapped, write-back, write-allocate cache
//   with one-word lines. Each accepted CPU access walks
//   IDLE -> LOOKUP -> [WB] -> [FILL] -> DONE. All outputs are registered.
// Ports:
//   clk, clr            clock; synchronous active-low reset
//   cpu_req/we/addr/din CPU request, sampled in IDLE only
//   cpu_dout/ready/busy CPU response; cache_hit valid with cpu_ready
//   mem_addr/rd/wr/dout memory request, held until mem_ack
//   mem_din/mem_ack     memory response
//   hit_cnt/miss_cnt    saturating access counters, only with
//                       MANO_CACHE_STATS_EN defined
module mano_cache_ctrl
  import mano_cache_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cache_hit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_ack
`ifdef MANO_CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_din_q, req_din_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;

  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic              cache_hit_q, cache_hit_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [DATA_W-1:0]  st_rd_data;
  logic [TAG_W-1:0]   st_rd_tag;
  logic               st_we;
  logic [DATA_W-1:0]  st_wr_data;
  line_t              cur;
  logic               hit;

  assign idx     = req_addr_q[INDEX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];

  mano_cache_store u_store (
    .clk     (clk),
    .rd_idx  (idx),
    .rd_data (st_rd_data),
    .rd_tag  (st_rd_tag),
    .we      (st_we & clr),   // no array writes in a reset cycle
    .wr_idx  (idx),
    .wr_data (st_wr_data),
    .wr_tag  (req_tag)
  );

  assign cur = '{data: st_rd_data, tag: st_rd_tag,
                 dirty: dirty_q[idx], valid: valid_q[idx]};
  assign hit = cur.valid && (cur.tag == req_tag);

`ifdef MANO_CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_din_d   = req_din_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_ready_d = 1'b0;
    cpu_busy_d  = cpu_busy_q;
    cache_hit_d = cache_hit_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_dout_d  = mem_dout_q;
    st_we       = 1'b0;
    st_wr_data  = req_din_q;
`ifdef MANO_CACHE_STATS_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_addr_d = cpu_addr;
          req_we_d   = cpu_we;
          req_din_d  = cpu_din;
          cpu_busy_d = 1'b1;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        cache_hit_d = hit;
`ifdef MANO_CACHE_STATS_EN
        if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
`endif
        if (hit) begin
          if (req_we_q) begin
            st_we        = 1'b1;
            dirty_d[idx] = 1'b1;
          end else begin
            cpu_dout_d = cur.data;
          end
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end else if (cur.valid && cur.dirty) begin
          // Victim goes back to memory under its own tag first.
          mem_wr_d   = 1'b1;
          mem_addr_d = {cur.tag, idx};
          mem_dout_d = cur.data;
          state_d    = WB;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = req_addr_q;
          state_d    = FILL;
        end
      end

      WB: begin
        if (mem_ack) begin
          mem_wr_d     = 1'b0;
          dirty_d[idx] = 1'b0;
          mem_rd_d     = 1'b1;
          mem_addr_d   = req_addr_q;
          state_d      = FILL;
        end
      end

      FILL: begin
        if (mem_ack) begin
          mem_rd_d     = 1'b0;
          st_we        = 1'b1;
          valid_d[idx] = 1'b1;
          if (req_we_q) begin
            // One-word line: the write data replaces the refill entirely.
            dirty_d[idx] = 1'b1;
          end else begin
            st_wr_data   = mem_din;
            dirty_d[idx] = 1'b0;
            cpu_dout_d   = mem_din;
          end
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        cpu_busy_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        cpu_busy_d = 1'b0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      // Abandons any in-flight writeback; its dirty data is dropped.
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_din_q   <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_dout_q  <= '0;
      cpu_ready_q <= 1'b0;
      cpu_busy_q  <= 1'b0;
      cache_hit_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= '0;
`ifdef MANO_CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_din_q   <= req_din_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_busy_q  <= cpu_busy_d;
      cache_hit_q <= cache_hit_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_dout_q  <= mem_dout_d;
`ifdef MANO_CACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_busy  = cpu_busy_q;
  assign cache_hit = cache_hit_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_dout  = mem_dout_q;
`ifdef MANO_CACHE_STATS_EN
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mano_cache_ctrl.sv
// tb_mano_cache_ctrl
//   Directed vector table of CPU accesses with hand-computed responses,
//   plus hand-written sequences for reset during writeback and a request
//   pulsed while a miss is outstanding. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_mano_cache_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [15:0] cpu_dout;
  logic        cpu_ready, cpu_busy, cache_hit;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_dout;
  logic [15:0] mem_din = '0;
  logic        mem_ack = 1'b0;
`ifdef MANO_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  mano_cache_ctrl dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .cache_hit(cache_hit),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
`ifdef MANO_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] din;
    int          dly;      // ack in the dly-th cycle the mem request is visible
    logic [15:0] fill;
    int          lat;      // cycles from acceptance edge to cpu_ready
    logic        hit;
    logic [15:0] dout;
    logic        wb;
    logic [11:0] wb_addr;
    logic [15:0] wb_data;
    logic        rd;
    logic [11:0] rd_addr;
  } vec_t;

  vec_t vecs[12];

  // Drives one access, plays memory, and observes the response.
  // bad flags read/write overlap, unstable memory request, or busy shape errors.
  task automatic access(input logic we, input logic [11:0] addr, input logic [15:0] din,
                        input int dly, input logic [15:0] fill, input bit inject,
                        output int lat, output int n_rdy, output logic [15:0] dout,
                        output logic hit, output logic saw_wr, output logic [11:0] wr_addr,
                        output logic [15:0] wr_data, output logic saw_rd,
                        output logic [11:0] rd_addr, output logic bad);
    int  wr_k, rd_k;
    bit  injected;
    lat = -1; n_rdy = 0; dout = '0; hit = 1'b0; saw_wr = 1'b0; wr_addr = '0;
    wr_data = '0; saw_rd = 1'b0; rd_addr = '0; bad = 1'b0;
    wr_k = 0; rd_k = 0; injected = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      cpu_req = 1'b0; mem_ack = 1'b0; mem_din = '0;
      if (mem_rd && mem_wr) bad = 1'b1;
      if (mem_wr) begin
        wr_k++;
        if (!saw_wr) begin saw_wr = 1'b1; wr_addr = mem_addr; wr_data = mem_dout; end
        else if (mem_addr !== wr_addr || mem_dout !== wr_data) bad = 1'b1;
        if (wr_k == dly) mem_ack = 1'b1;
      end
      if (mem_rd) begin
        rd_k++;
        if (!saw_rd) begin saw_rd = 1'b1; rd_addr = mem_addr; end
        else if (mem_addr !== rd_addr) bad = 1'b1;
        if (inject && !injected) begin
          cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ~addr; injected = 1'b1;
        end
        if (rd_k == dly) begin mem_ack = 1'b1; mem_din = fill; end
      end
      if (cpu_ready) begin
        n_rdy++;
        if (lat < 0) begin lat = cyc; dout = cpu_dout; hit = cache_hit; end
      end
      if (cpu_busy !== ((lat < 0) || (cyc == lat))) bad = 1'b1;
      if (lat >= 0 && cyc >= lat + 2) break;
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat, n_rdy;
    logic [15:0] dout, wr_data;
    logic hit, saw_wr, saw_rd, bad;
    logic [11:0] wr_addr, rd_addr;
    access(v.we, v.addr, v.din, v.dly, v.fill, 1'b0, lat, n_rdy, dout, hit,
           saw_wr, wr_addr, wr_data, saw_rd, rd_addr, bad);
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " ready_pulses"}, n_rdy, 1);
    chk({nm, " cache_hit"}, {31'd0, hit}, {31'd0, v.hit});
    chk({nm, " cpu_dout"}, {16'd0, dout}, {16'd0, v.dout});
    chk({nm, " mem_wr_seen"}, {31'd0, saw_wr}, {31'd0, v.wb});
    chk({nm, " mem_rd_seen"}, {31'd0, saw_rd}, {31'd0, v.rd});
    chk({nm, " protocol"}, {31'd0, bad}, 32'd0);
    if (v.wb) begin
      chk({nm, " wb_addr"}, {20'd0, wr_addr}, {20'd0, v.wb_addr});
      chk({nm, " wb_data"}, {16'd0, wr_data}, {16'd0, v.wb_data});
    end
    if (v.rd) chk({nm, " rd_addr"}, {20'd0, rd_addr}, {20'd0, v.rd_addr});
  endtask

  initial begin
    int lat, n_rdy, waited;
    logic [15:0] dout, wr_data;
    logic hit, saw_wr, saw_rd, bad;
    logic [11:0] wr_addr, rd_addr;

    //          we    addr     din      dly fill     lat hit dout     wb  wb_addr  wb_data  rd  rd_addr
    vecs[0]  = '{1'b0, 12'h123, 16'h0000, 3, 16'hBEEF, 5, 1'b0, 16'hBEEF, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h123};
    vecs[1]  = '{1'b0, 12'h123, 16'h0000, 1, 16'h0000, 2, 1'b1, 16'hBEEF, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000};
    vecs[2]  = '{1'b1, 12'h123, 16'h1234, 1, 16'h0000, 2, 1'b1, 16'hBEEF, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000};
    vecs[3]  = '{1'b0, 12'h123, 16'h0000, 1, 16'h0000, 2, 1'b1, 16'h1234, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000};
    vecs[4]  = '{1'b0, 12'h523, 16'h0000, 2, 16'h5555, 6, 1'b0, 16'h5555, 1'b1, 12'h123, 16'h1234, 1'b1, 12'h523};
    vecs[5]  = '{1'b0, 12'h523, 16'h0000, 1, 16'h0000, 2, 1'b1, 16'h5555, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000};
    vecs[6]  = '{1'b1, 12'h7FF, 16'hAAAA, 1, 16'hDEAD, 3, 1'b0, 16'h5555, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h7FF};
    vecs[7]  = '{1'b0, 12'h0FF, 16'h0000, 1, 16'h0F0F, 4, 1'b0, 16'h0F0F, 1'b1, 12'h7FF, 16'hAAAA, 1'b1, 12'h0FF};
    vecs[8]  = '{1'b0, 12'h7FF, 16'h0000, 1, 16'h7777, 3, 1'b0, 16'h7777, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h7FF};
    vecs[9]  = '{1'b1, 12'h000, 16'h0001, 1, 16'hCCCC, 3, 1'b0, 16'h7777, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h000};
    vecs[10] = '{1'b0, 12'h000, 16'h0000, 1, 16'h0000, 2, 1'b1, 16'h0001, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000};
    vecs[11] = '{1'b1, 12'h123, 16'h4321, 1, 16'hEEEE, 3, 1'b0, 16'h0001, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h123};

    // Reset state
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst cpu_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst cache_hit", {31'd0, cache_hit}, 32'd0);
    chk("rst cpu_dout", {16'd0, cpu_dout}, 32'd0);
    chk("rst mem_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst mem_addr_dout", {4'd0, mem_addr, mem_dout}, 32'd0);
    clr = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

`ifdef MANO_CACHE_STATS_EN
    chk("stats hit_cnt", {16'd0, hit_cnt}, 32'd5);
    chk("stats miss_cnt", {16'd0, miss_cnt}, 32'd7);
`endif

    // Reset while a writeback is outstanding: line 0x23 holds dirty tag 1.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h523;
    @(negedge clk);
    cpu_req = 1'b0;
    waited = 0;
    while (!mem_wr && waited < 10) begin @(negedge clk); waited++; end
    chk("wbrst mem_wr_seen", {31'd0, mem_wr}, 32'd1);
    chk("wbrst wb_addr", {20'd0, mem_addr}, 32'h123);
    chk("wbrst wb_data", {16'd0, mem_dout}, 32'h4321);
    repeat (2) @(negedge clk);
    chk("wbrst wr_held", {31'd0, mem_wr}, 32'd1);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    chk("wbrst mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("wbrst cpu_busy", {31'd0, cpu_busy}, 32'd0);
    chk("wbrst mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("wbrst cpu_dout", {16'd0, cpu_dout}, 32'd0);
`ifdef MANO_CACHE_STATS_EN
    chk("wbrst hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("wbrst miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif

    // Valid bits are gone: 0x123 must miss cleanly.
    access(1'b0, 12'h123, 16'h0, 1, 16'h9999, 1'b0, lat, n_rdy, dout, hit,
           saw_wr, wr_addr, wr_data, saw_rd, rd_addr, bad);
    chk("post latency", lat, 3);
    chk("post cache_hit", {31'd0, hit}, 32'd0);
    chk("post mem_wr_seen", {31'd0, saw_wr}, 32'd0);
    chk("post mem_rd_seen", {31'd0, saw_rd}, 32'd1);
    chk("post rd_addr", {20'd0, rd_addr}, 32'h123);
    chk("post cpu_dout", {16'd0, dout}, 32'h9999);
    chk("post protocol", {31'd0, bad}, 32'd0);

    // Request pulsed during the miss wait is ignored.
    access(1'b0, 12'h456, 16'h0, 3, 16'h4567, 1'b1, lat, n_rdy, dout, hit,
           saw_wr, wr_addr, wr_data, saw_rd, rd_addr, bad);
    chk("inj latency", lat, 5);
    chk("inj ready_pulses", n_rdy, 1);
    chk("inj cache_hit", {31'd0, hit}, 32'd0);
    chk("inj cpu_dout", {16'd0, dout}, 32'h4567);
    chk("inj protocol", {31'd0, bad}, 32'd0);
    repeat (3) @(negedge clk);
    chk("inj idle_busy", {31'd0, cpu_busy}, 32'd0);
    chk("inj idle_mem", {30'd0, mem_rd, mem_wr}, 32'd0);

    access(1'b0, 12'h456, 16'h0, 1, 16'h0, 1'b0, lat, n_rdy, dout, hit,
           saw_wr, wr_addr, wr_data, saw_rd, rd_addr, bad);
    chk("rehit latency", lat, 2);
    chk("rehit cache_hit", {31'd0, hit}, 32'd1);
    chk("rehit cpu_dout", {16'd0, dout}, 32'h4567);
`ifdef MANO_CACHE_STATS_EN
    chk("final hit_cnt", {16'd0, hit_cnt}, 32'd1);
    chk("final miss_cnt", {16'd0, miss_cnt}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
